zoh_upsample: RTL and testbench
===============================

// Module: zoh_upsample
// PURPOSE
//  Lossless zero-order-hold upsampler on the dti stream protocol; the producer-side counterpart of the lossy sampler.
//  - Consumes one din transaction and replays its data on dout exactly RATIO times.
//  - Applies back-pressure on din until the last copy is handshaken.
//  - Sits between a slow-rate producer and a fast-rate consumer.
// PARAMETERS
//  RATIO      4  copies emitted per din transaction; legal >= 1; RATIO=1 acts as a pass-through stage.
//  HOLD       1  1: after RATIO copies, keep presenting the last value (dout.valid=1) until new din; 0: drop dout.valid.
//  LATENCY    0  0: din.data bypasses to dout in the same cycle when the stage can accept; 1: registered output only.
//  INIT       0  data value loaded at reset when INIT_VALID=1.
//  INIT_VALID 0  1: INIT is treated as an accepted transaction at reset.
// PORTS
//  clk   in   1    clock
//  rst   in   1    reset
//  din   dti.consumer  $size(din.data)  input stream (data, valid, ready)
//  dout  dti.producer  $size(din.data)  output stream (data, valid, ready); data width equals din
// BEHAVIOUR
//  Reset and handshake:
//  - Reset: rst is synchronous, active-high; clock is clk.
//  - Handshake = valid && ready on the same posedge; dout.valid never drops before its handshake.
//  - Registers: data_reg, cnt (0..RATIO-1), state {EMPTY, EMIT, HELD}.
//  - rst: INIT_VALID=0 -> state=EMPTY, cnt=0. INIT_VALID=1 -> state=EMIT, cnt=0, data_reg=INIT.
//  - rst mid-operation discards remaining copies; din is not consumed during the rst cycle.
//  Accept condition (acc):
//  - acc = state in {EMPTY, HELD}, or (state==EMIT && cnt==RATIO-1 && dout.ready).
//  - din.ready = acc (combinational from dout.ready).
//  - din handshake: data_reg<=din.data; state<=EMIT; cnt<=0, or cnt<=1 if copy 0 was also handshaken via bypass.
//  - Bypass with RATIO=1: state goes directly to HELD/EMPTY instead of EMIT.
//  Output, LATENCY=1:
//  - dout.data = data_reg.
//  - dout.valid = (state==EMIT) || (state==HELD && HOLD).
//  Output, LATENCY=0:
//  - When state in {EMPTY, HELD} and din.valid: dout.data=din.data, dout.valid=1 (bypass).
//  - Otherwise the LATENCY=1 output rule applies.
//  - EMPTY with no din.valid: dout.valid=0.
//  EMIT copy counting:
//  - Each dout handshake: cnt<=cnt+1.
//  - On the handshake at cnt==RATIO-1: cnt<=0 and state<=HELD (HOLD=1) or EMPTY (HOLD=0), unless din is accepted that cycle.
//  - Simultaneous last-copy handshake and din.valid: new data loaded, state stays EMIT, cnt=0; zero bubble between groups.
//  HELD state:
//  - dout handshakes of the held value do not advance cnt and do not count as copies.
//  - New din always wins.
//  Ordering, stalls and widths:
//  - dout.ready low: outputs and cnt frozen; dout.valid held.
//  - din.valid low: HOLD=0 leaves a gap; HOLD=1 replays the held value.
//  - Ordering: copies of din item N all precede any copy of item N+1.
//  - cnt width = max(1, $clog2(RATIO)); cnt never exceeds RATIO-1 (no wrap beyond the terminal count).
//  - Throughput, both latencies: one dout beat per cycle while dout.ready=1; din rate = 1/RATIO.
//  - Latency: LATENCY=0 -> 0 cycles din->first copy. LATENCY=1 -> 1 cycle.
// STRUCTURE
//  - Shared package: typedef enum logic [1:0] {EMPTY, EMIT, HELD} zoh_state_t.
//  - Shared package: localparam function for cnt width.
//  - Single module; no sub-module.
//  - Copy counter coded inline; the control path is one FSM always block plus one datapath always block.
// TESTING
//  1. RATIO=4, LATENCY=1, dout.ready=1; din 0xA5 once
//     -> dout 0xA5 x4 on cycles 1..4; din.ready low cycles 1..3.
//  2. RATIO=3, LATENCY=0, din back-to-back 1,2,3, dout.ready=1
//     -> dout 1,1,1,2,2,2,3,3,3 with no gaps; din.ready high every 3rd cycle.
//  3. RATIO=2, HOLD=1, single din 7, dout.ready=1 for 6 cycles
//     -> dout 7 valid all 6 cycles.
//  3b. Same as 3 with HOLD=0
//     -> dout 7,7 then dout.valid=0.
//  4. RATIO=4, random dout.ready 50%, 100 random din items
//     -> scoreboard: each item appears exactly 4 consecutive times, order preserved, no data change while valid && !ready.
//  5. INIT_VALID=1, INIT=0x3C, RATIO=2, no din
//     -> after rst dout 0x3C x2 (then held if HOLD=1).
//  5b. rst asserted at cnt=2 of RATIO=4
//     -> next cycle state EMPTY, dout.valid=0 (LATENCY=1).
//  6. RATIO=1, LATENCY=0
//     -> dout mirrors din combinationally.
//  6b. RATIO=1, LATENCY=1
//     -> one-cycle registered stage, full throughput.

Source files
------------

// File: rtl/zoh_upsample_pkg.sv
// rtl/zoh_upsample_pkg.sv - shared types and helpers for the zero-order-hold upsampler
//
// Purpose: state encoding and copy-counter width helper used by zoh_upsample.
// Ports:   none (package).

package zoh_upsample_pkg;

  // EMPTY: nothing to present; EMIT: replaying copies of data_q;
  // HELD: all copies delivered, last value retained for optional replay.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    EMIT  = 2'd1,
    HELD  = 2'd2
  } zoh_state_t;

  // Copy counter must index 0..ratio-1 but is never narrower than one bit.
  function automatic int zoh_cnt_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/zoh_upsample.sv
// rtl/zoh_upsample.sv - lossless zero-order-hold upsampler on a valid/ready stream
//
// Purpose: accepts one din beat and replays its data on dout exactly RATIO
//          times, back-pressuring din until the last copy is handshaken.
//          LATENCY=0 lets din bypass straight to dout when the stage is idle;
//          HOLD=1 keeps presenting the last value after the group completes.
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous, active-high reset
//   din_data   in   WIDTH  input stream data
//   din_valid  in   1      input stream valid
//   din_ready  out  1      input stream ready (combinational from dout_ready)
//   dout_data  out  WIDTH  output stream data
//   dout_valid out  1      output stream valid
//   dout_ready in   1      output stream ready

module zoh_upsample
  import zoh_upsample_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               RATIO      = 4,
  parameter int               HOLD       = 1,
  parameter int               LATENCY    = 0,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               INIT_VALID = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_data,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int             CW          = zoh_cnt_width(RATIO);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(RATIO - 1);
  localparam zoh_state_t     DONE_STATE  = (HOLD != 0) ? HELD : EMPTY;
  localparam bit             BYPASS_EN   = (LATENCY == 0);
  localparam bit             SINGLE_COPY = (RATIO == 1);

  zoh_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic bypass;
  logic last_copy;
  logic acc;
  logic din_hs;
  logic dout_hs;

  // Output mux: an idle stage (EMPTY/HELD) forwards din directly when the
  // bypass is enabled; otherwise the registered value is presented.
  always_comb begin
    bypass    = BYPASS_EN && (state_q != EMIT) && din_valid;
    last_copy = (state_q == EMIT) && (cnt_q == CNT_LAST);
    if (bypass) begin
      dout_data  = din_data;
      dout_valid = 1'b1;
    end else begin
      dout_data  = data_q;
      dout_valid = (state_q == EMIT) || ((state_q == HELD) && (HOLD != 0));
    end
    // New din is taken whenever no copies are outstanding, or in the same
    // cycle the final copy leaves, giving zero bubbles between groups.
    acc       = (state_q != EMIT) || (last_copy && dout_ready);
    din_ready = acc && !rst;
    din_hs    = din_valid && din_ready;
    dout_hs   = dout_valid && dout_ready;
  end

  // Control FSM with the copy counter coded inline.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (din_hs) begin
      if (bypass && dout_ready) begin
        // Copy 0 already left through the bypass this cycle.
        if (SINGLE_COPY) begin
          state_d = DONE_STATE;
          cnt_d   = '0;
        end else begin
          state_d = EMIT;
          cnt_d   = CW'(1);
        end
      end else begin
        state_d = EMIT;
        cnt_d   = '0;
      end
    end else if ((state_q == EMIT) && dout_hs) begin
      if (cnt_q == CNT_LAST) begin
        state_d = DONE_STATE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Handshakes of a HELD value are replays, not copies: cnt untouched.
  end

  // Datapath: capture din on every accepted transaction.
  always_comb begin
    data_d = data_q;
    if (din_hs) begin
      data_d = din_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_VALID != 0) ? EMIT : EMPTY;
      cnt_q   <= '0;
      data_q  <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_zoh_upsample.sv
// tb/tb_zoh_upsample.sv - self-checking bench for zoh_upsample

module tb_zoh_upsample;

  logic       clk;
  logic       rst;
  logic [7:0] din_data;
  logic       din_valid;
  logic       dout_ready;

  logic [7:0] dout_data_w  [7];
  logic       dout_valid_w [7];
  logic       din_ready_w  [7];

  // Per-instance configuration, mirrored from the parameter overrides below.
  int cfg_ratio [7] = '{4, 3, 2, 2, 2, 1, 1};
  int cfg_lat   [7] = '{1, 0, 1, 1, 1, 0, 1};
  int cfg_hold  [7] = '{1, 1, 1, 0, 1, 0, 0};

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] sbq [$];
  logic [7:0] last_v;
  logic [7:0] stall_d;
  logic       stall_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  zoh_upsample #(.WIDTH(8), .RATIO(4), .HOLD(1), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[0]),
    .dout_data(dout_data_w[0]), .dout_valid(dout_valid_w[0]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(3), .HOLD(1), .LATENCY(0)) u_b (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[1]),
    .dout_data(dout_data_w[1]), .dout_valid(dout_valid_w[1]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(2), .HOLD(1), .LATENCY(1)) u_c (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[2]),
    .dout_data(dout_data_w[2]), .dout_valid(dout_valid_w[2]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(2), .HOLD(0), .LATENCY(1)) u_d (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[3]),
    .dout_data(dout_data_w[3]), .dout_valid(dout_valid_w[3]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(2), .HOLD(1), .LATENCY(1), .INIT(8'h3C), .INIT_VALID(1)) u_e (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[4]),
    .dout_data(dout_data_w[4]), .dout_valid(dout_valid_w[4]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(1), .HOLD(0), .LATENCY(0)) u_f (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[5]),
    .dout_data(dout_data_w[5]), .dout_valid(dout_valid_w[5]), .dout_ready(dout_ready));
  zoh_upsample #(.WIDTH(8), .RATIO(1), .HOLD(0), .LATENCY(1)) u_g (
    .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready_w[6]),
    .dout_data(dout_data_w[6]), .dout_valid(dout_valid_w[6]), .dout_ready(dout_ready));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = 8'h00;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_clear();
    sbq.delete();
    stall_q = 1'b0;
    stall_d = 8'h00;
    last_v  = 8'h00;
  endtask

  // Called at the negative edge, with inputs and outputs settled for the
  // coming posedge. Copies are pushed when din handshakes and popped when
  // dout handshakes; with the bypass the push must precede the pop.
  task automatic sb_sample(input int s);
    logic       v;
    logic [7:0] d;
    logic       pushed;
    logic       real_beat;
    v      = dout_valid_w[s];
    d      = dout_data_w[s];
    pushed = 1'b0;
    if (cfg_lat[s] == 0 && din_valid && din_ready_w[s]) begin
      for (int i = 0; i < cfg_ratio[s]; i++) sbq.push_back(din_data);
      pushed = 1'b1;
    end
    real_beat = (sbq.size() != 0);
    if (stall_q) begin
      check("stall_valid", 32'(v), 32'd1);
      check("stall_data", 32'(d), 32'(stall_d));
    end
    if (v && dout_ready) begin
      if (sbq.size() != 0) begin
        check("sb_data", 32'(d), 32'(sbq[0]));
        last_v = sbq.pop_front();
      end else if (cfg_hold[s] != 0) begin
        check("sb_held", 32'(d), 32'(last_v));
      end else begin
        check("sb_spurious", 32'(v), 32'd0);
      end
    end
    if (!pushed && din_valid && din_ready_w[s]) begin
      for (int i = 0; i < cfg_ratio[s]; i++) sbq.push_back(din_data);
    end
    stall_q = v && !dout_ready && real_beat;
    stall_d = d;
  endtask

  initial begin
    logic [7:0] items [3];
    logic [7:0] prev;
    int         ptr;
    int         sent;
    int         cyc;
    logic       hs;

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst_a_valid", 32'(dout_valid_w[0]), 32'd0);
    check("rst_a_ready", 32'(din_ready_w[0]), 32'd1);
    check("rst_b_valid", 32'(dout_valid_w[1]), 32'd0);

    // 1: single item, RATIO=4, LATENCY=1.
    next_drive();
    din_valid = 1'b1;
    din_data  = 8'hA5;
    @(negedge clk);
    check("t1_accept", 32'(din_ready_w[0]), 32'd1);
    check("t1_lat", 32'(dout_valid_w[0]), 32'd0);
    next_drive();
    din_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t1_valid", 32'(dout_valid_w[0]), 32'd1);
      check("t1_data", 32'(dout_data_w[0]), 32'hA5);
      if (k <= 4) check("t1_ready", 32'(din_ready_w[0]), 32'(k == 4));
      next_drive();
    end

    // 5b: reset mid-group at cnt=2.
    do_reset();
    din_valid = 1'b1;
    din_data  = 8'h11;
    next_drive();
    din_valid = 1'b0;
    next_drive();
    next_drive();
    rst = 1'b1;
    @(negedge clk);
    check("t5b_pre_valid", 32'(dout_valid_w[0]), 32'd1);
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    check("t5b_valid", 32'(dout_valid_w[0]), 32'd0);
    check("t5b_ready", 32'(din_ready_w[0]), 32'd1);

    // 2: RATIO=3, LATENCY=0, back-to-back items.
    do_reset();
    sb_clear();
    items = '{8'd1, 8'd2, 8'd3};
    ptr   = 0;
    for (int c = 0; c < 9; c++) begin
      din_valid = (ptr < 3);
      din_data  = (ptr < 3) ? items[ptr] : 8'h00;
      @(negedge clk);
      hs = din_valid && din_ready_w[1];
      check("t2_ready", 32'(din_ready_w[1]), 32'((c == 0) || (c % 3 == 2)));
      check("t2_nogap", 32'(dout_valid_w[1]), 32'd1);
      sb_sample(1);
      if (hs) ptr++;
      next_drive();
    end
    din_valid = 1'b0;
    check("t2_items", 32'(ptr), 32'd3);
    check("t2_sb_empty", 32'(sbq.size()), 32'd0);

    // 3 / 3b / 5: RATIO=2 with HOLD=1 and HOLD=0; INIT_VALID instance.
    do_reset();
    din_valid = 1'b1;
    din_data  = 8'h07;
    @(negedge clk);
    check("t3_lat", 32'(dout_valid_w[2]), 32'd0);
    check("t3b_lat", 32'(dout_valid_w[3]), 32'd0);
    check("t5_valid0", 32'(dout_valid_w[4]), 32'd1);
    check("t5_data0", 32'(dout_data_w[4]), 32'h3C);
    check("t5_ready0", 32'(din_ready_w[4]), 32'd0);
    next_drive();
    din_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("t3_valid", 32'(dout_valid_w[2]), 32'd1);
      check("t3_data", 32'(dout_data_w[2]), 32'h07);
      check("t3b_valid", 32'(dout_valid_w[3]), 32'(c <= 2));
      if (c <= 2) check("t3b_data", 32'(dout_data_w[3]), 32'h07);
      check("t5_valid", 32'(dout_valid_w[4]), 32'd1);
      check("t5_data", 32'(dout_data_w[4]), 32'h3C);
      next_drive();
    end

    // 6 / 6b: RATIO=1 pass-through, combinational and registered.
    do_reset();
    prev = 8'h00;
    for (int c = 0; c < 8; c++) begin
      din_valid = 1'b1;
      din_data  = 8'($urandom);
      @(negedge clk);
      check("t6_valid", 32'(dout_valid_w[5]), 32'd1);
      check("t6_data", 32'(dout_data_w[5]), 32'(din_data));
      check("t6_ready", 32'(din_ready_w[5]), 32'd1);
      check("t6b_ready", 32'(din_ready_w[6]), 32'd1);
      if (c > 0) begin
        check("t6b_valid", 32'(dout_valid_w[6]), 32'd1);
        check("t6b_data", 32'(dout_data_w[6]), 32'(prev));
      end
      prev = din_data;
      next_drive();
    end
    din_valid = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(dout_valid_w[5]), 32'd0);
    check("t6b_tail_valid", 32'(dout_valid_w[6]), 32'd1);
    check("t6b_tail_data", 32'(dout_data_w[6]), 32'(prev));
    next_drive();
    @(negedge clk);
    check("t6b_idle", 32'(dout_valid_w[6]), 32'd0);

    // 4: RATIO=4 with random back-pressure and 100 random items.
    do_reset();
    sb_clear();
    sent = 0;
    cyc  = 0;
    hs   = 1'b0;
    while ((sent < 100 || sbq.size() != 0) && cyc < 4000) begin
      if (hs) din_valid = 1'b0;
      dout_ready = 1'($urandom % 2);
      if (!din_valid && sent < 100 && ($urandom % 4) != 0) begin
        din_valid = 1'b1;
        din_data  = 8'($urandom);
      end
      @(negedge clk);
      hs = din_valid && din_ready_w[0];
      sb_sample(0);
      if (hs) sent++;
      next_drive();
      cyc++;
    end
    din_valid = 1'b0;
    check("t4_done", 32'(cyc < 4000), 32'd1);
    check("t4_items", 32'(sent), 32'd100);
    check("t4_sb_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
